// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the staged reset sequencer:
//   - state_t      : sequencer state encoding (RESET, HOLD, MEM, CPU, RUN)
//   - DEF_*        : default values for the sequencer parameters
//   - cnt_width()  : width of the shared stage counter
// ---------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [2:0] {
    RESET = 3'd0,  // all resets asserted, waiting for synchronised release
    HOLD  = 3'd1,  // all resets asserted, stretching
    MEM   = 3'd2,  // memory released
    CPU   = 3'd3,  // memory and CPU released
    RUN   = 3'd4   // everything released
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_HOLD_CYCLES  = 64;
  localparam int unsigned DEF_STAGE_CYCLES = 16;

  // Counter must hold values up to max(hold, stage)-1, and at least the
  // constant 1 loaded when leaving RESET, so it is never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned stage);
    int unsigned m;
    int unsigned w;
    m = (hold > stage) ? hold : stage;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// ---------------------------------------------------------------------------
// rst_sync
// Reset release synchroniser: a SYNC_STAGES-deep flop chain that is cleared
// asynchronously by rst_ and shifts in a constant 1 once rst_ is high, so
// assertion is immediate while deassertion is aligned to clk.
// Ports:
//   clk     : system clock
//   rst_    : asynchronous active-low reset
//   rst_rel : synchronised release, high SYNC_STAGES edges after rst_ rises
// ---------------------------------------------------------------------------
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_,
  output logic rst_rel
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: flops are written with non-blocking assignments so every stage
  // samples the previous stage's old value; blocking here would collapse
  // the chain into a single flop.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_rel = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq
// Staged reset sequencer. Synchronises the release of the clock generator's
// lock-qualified reset, stretches it, then releases memory, CPU and display
// in that order with a fixed spacing between releases.
//
// Optional feature (macro RST_SEQ_SOFT_RST_EN): a soft-reset request sampled
// in RUN re-runs the CPU/display part of the sequence while memory stays out
// of reset. Without the macro the request input is ignored and RUN is
// terminal until rst_ falls.
//
// Ports:
//   clk          : 100 MHz system clock
//   rst_         : asynchronous active-low reset (async assert, sync release)
//   soft_rst_req : synchronous soft-reset request
//   mem_rst      : active-high memory-controller reset
//   cpu_rst      : active-high CPU reset
//   vdu_rst      : active-high display-unit reset
//   ready        : high when all subsystems are out of reset
// ---------------------------------------------------------------------------
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_CYCLES = DEF_STAGE_CYCLES
) (
  input  logic clk,
  input  logic rst_,
  input  logic soft_rst_req,
  output logic mem_rst,
  output logic cpu_rst,
  output logic vdu_rst,
  output logic ready
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rst_rel;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk    (clk),
    .rst_   (rst_),
    .rst_rel(rst_rel)
  );

`ifndef RST_SEQ_SOFT_RST_EN
  // Port kept for a stable interface; nothing consumes it in this build.
  logic unused_soft_rst_req;
  assign unused_soft_rst_req = soft_rst_req;
`endif

  // NOTE: every flop here, counter included, is cleared by the asynchronous
  // reset so a glitch on rst_ of any width returns the outputs to their
  // reset values without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= RESET;
      cnt     <= '0;
      mem_rst <= 1'b1;
      cpu_rst <= 1'b1;
      vdu_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          // The edge that leaves RESET already counts as the first hold
          // cycle, which puts the memory release on edge
          // SYNC_STAGES+HOLD_CYCLES.
          if (rst_rel) begin
            if (HOLD_CYCLES == 1) begin
              state   <= MEM;
              cnt     <= '0;
              mem_rst <= 1'b0;
            end else begin
              state <= HOLD;
              cnt   <= CNT_ONE;
            end
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state   <= MEM;
            cnt     <= '0;
            mem_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        MEM: begin
          if (cnt == STAGE_LAST) begin
            state   <= CPU;
            cnt     <= '0;
            cpu_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        CPU: begin
          if (cnt == STAGE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            vdu_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RUN: begin
`ifdef RST_SEQ_SOFT_RST_EN
          // Soft reset re-enters MEM; memory stays released.
          if (soft_rst_req) begin
            state   <= MEM;
            cnt     <= '0;
            cpu_rst <= 1'b1;
            vdu_rst <= 1'b1;
            ready   <= 1'b0;
          end
`endif
        end

        default: begin
          state   <= RESET;
          cnt     <= '0;
          mem_rst <= 1'b1;
          cpu_rst <= 1'b1;
          vdu_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
